// File: rtl/gol_pkg.sv
// Shared constants and the scan FSM state type for the game-of-life display path.
package gol_pkg;
    localparam int GRID_W = 64;
    localparam int ROWS   = 8;
    localparam int COLS   = 8;
    localparam int CNT_W  = 7;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        BLANK
    } scan_state_t;
endpackage

// File: rtl/popcount64.sv
// Combinational population count of a 64-bit grid; 7-bit result covers 0..64.
module popcount64
    import gol_pkg::*;
(
    input  logic [GRID_W-1:0] i_bits,
    output logic [CNT_W-1:0]  o_count
);
    logic [CNT_W-1:0] w_sum;

    always_comb begin
        w_sum = '0;
        for (int unsigned i = 0; i < GRID_W; i++) begin
            w_sum = w_sum + CNT_W'(i_bits[i]);
        end
    end

    assign o_count = w_sum;
endmodule

// File: rtl/grid_display_scan.sv
// Accepts one 8x8 grid snapshot and scans it row-by-row onto a multiplexed LED
// matrix with per-row dwell, a blanking cycle between rows, and a frame_done pulse.
module grid_display_scan
    import gol_pkg::*;
#(
    parameter int DWELL_CYCLES   = 4,
    parameter int FRAMES_PER_GEN = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [GRID_W-1:0] grid,
    input  logic              grid_valid,
    output logic              grid_ready,
    output logic [ROWS-1:0]   row_sel,
    output logic [COLS-1:0]   col_data,
    output logic [CNT_W-1:0]  live_count,
    output logic              frame_done
);
    localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int FR_W = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
    localparam logic [FR_W-1:0] FRAME_LAST = FR_W'(FRAMES_PER_GEN - 1);
    localparam logic [2:0]      ROW_LAST   = 3'(ROWS - 1);

    scan_state_t       r_state;
    logic [2:0]        r_row;
    logic [DW_W-1:0]   r_dwell;
    logic [FR_W-1:0]   r_frame;
    logic [GRID_W-1:0] r_snap;
    logic [ROWS-1:0]   r_row_sel;
    logic [COLS-1:0]   r_col_data;
    logic [CNT_W-1:0]  r_live_count;
    logic              r_frame_done;

    scan_state_t       w_state_next;
    logic [2:0]        w_row_next;
    logic [DW_W-1:0]   w_dwell_next;
    logic [FR_W-1:0]   w_frame_next;
    logic [GRID_W-1:0] w_snap_next;
    logic [CNT_W-1:0]  w_count_next;
    logic              w_done_next;
    logic [ROWS-1:0]   w_row_sel_next;
    logic [COLS-1:0]   w_col_next;
    logic [CNT_W-1:0]  w_pop;

    popcount64 u_popcount (
        .i_bits  (grid),
        .o_count (w_pop)
    );

    always_comb begin
        w_state_next = r_state;
        w_row_next   = r_row;
        w_dwell_next = r_dwell;
        w_frame_next = r_frame;
        w_snap_next  = r_snap;
        w_count_next = r_live_count;
        w_done_next  = 1'b0;
        case (r_state)
            IDLE: begin
                if (grid_valid) begin
                    w_snap_next  = grid;
                    w_count_next = w_pop;
                    w_state_next = SCAN;
                    w_row_next   = '0;
                    w_dwell_next = '0;
                    w_frame_next = '0;
                end
            end
            SCAN: begin
                if (r_dwell == DWELL_LAST) begin
                    w_state_next = BLANK;
                    w_dwell_next = '0;
                    // The final blank of the final frame carries the done pulse.
                    w_done_next  = (r_row == ROW_LAST) && (r_frame == FRAME_LAST);
                end else begin
                    w_dwell_next = r_dwell + 1'b1;
                end
            end
            BLANK: begin
                if (r_row != ROW_LAST) begin
                    w_row_next   = r_row + 1'b1;
                    w_state_next = SCAN;
                end else if (r_frame != FRAME_LAST) begin
                    w_frame_next = r_frame + 1'b1;
                    w_row_next   = '0;
                    w_state_next = SCAN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase

        // Display outputs are registered, so they are decoded from next-state values.
        w_row_sel_next = '0;
        w_col_next     = '0;
        if (w_state_next == SCAN) begin
            w_row_sel_next = ROWS'(1) << w_row_next;
            w_col_next     = w_snap_next[{w_row_next, 3'b000} +: COLS];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_row        <= '0;
            r_dwell      <= '0;
            r_frame      <= '0;
            r_snap       <= '0;
            r_row_sel    <= '0;
            r_col_data   <= '0;
            r_live_count <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_row        <= w_row_next;
            r_dwell      <= w_dwell_next;
            r_frame      <= w_frame_next;
            r_snap       <= w_snap_next;
            r_row_sel    <= w_row_sel_next;
            r_col_data   <= w_col_next;
            r_live_count <= w_count_next;
            r_frame_done <= w_done_next;
        end
    end

    assign grid_ready = (r_state == IDLE);
    assign row_sel    = r_row_sel;
    assign col_data   = r_col_data;
    assign live_count = r_live_count;
    assign frame_done = r_frame_done;
endmodule

// File: tb/tb_grid_display_scan.sv
// Randomized self-checking bench for grid_display_scan: default instance and a
// DWELL_CYCLES=1 / FRAMES_PER_GEN=1 instance, checked against a timeline model.
module tb_grid_display_scan;
    logic        clk;
    logic        reset;
    logic [63:0] grid_a, grid_b;
    logic        valid_a, valid_b;
    logic        ready_a, ready_b;
    logic [7:0]  row_sel_a, row_sel_b, col_a, col_b;
    logic [6:0]  live_a, live_b;
    logic        done_a, done_b;
    logic        prev_done_a, prev_done_b;
    int          checks;
    int          errors;

    grid_display_scan #(.DWELL_CYCLES(4), .FRAMES_PER_GEN(2)) dut (
        .clk(clk), .reset(reset), .grid(grid_a), .grid_valid(valid_a),
        .grid_ready(ready_a), .row_sel(row_sel_a), .col_data(col_a),
        .live_count(live_a), .frame_done(done_a)
    );

    grid_display_scan #(.DWELL_CYCLES(1), .FRAMES_PER_GEN(1)) dut1 (
        .clk(clk), .reset(reset), .grid(grid_b), .grid_valid(valid_b),
        .grid_ready(ready_b), .row_sel(row_sel_b), .col_data(col_b),
        .live_count(live_b), .frame_done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference timeline: cycle k counts from the accept edge (k=0).
    function automatic void model(input logic [63:0] g, input int k, input int d,
                                  input int f, output logic [7:0] rs,
                                  output logic [7:0] cd, output logic fd,
                                  output logic rdy);
        int p, n, pos, row, ph;
        p = d + 1;
        n = f * 8 * p;
        rs = 8'h00; cd = 8'h00; fd = 1'b0; rdy = 1'b1;
        if (k <= n) begin
            rdy = 1'b0;
            pos = (k - 1) % (8 * p);
            row = pos / p;
            ph  = pos % p;
            if (ph < d) begin
                rs = 8'h01 << row;
                cd = g[8*row +: 8];
            end
            fd = (k == n);
        end
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            checks++;
            if (!$onehot0(row_sel_a) || !$onehot0(row_sel_b)) begin
                errors++;
                $display("FAIL onehot row_sel a=%h b=%h required one-hot or zero", row_sel_a, row_sel_b);
            end
            checks++;
            if ((done_a && prev_done_a) || (done_b && prev_done_b)) begin
                errors++;
                $display("FAIL done_twice frame_done high two cycles a=%b b=%b required single pulse", done_a, done_b);
            end
        end
        prev_done_a <= done_a;
        prev_done_b <= done_b;
    end

    // Accepts g on the selected instance and checks every cycle through the
    // return of grid_ready. With noise set, grid_valid stays high with random
    // grids during the scan and next_g is presented for the following accept.
    task automatic run_scan(input bit inst, input logic [63:0] g, input bit noise,
                            input logic [63:0] next_g, input string name);
        int d, f, n, waited;
        logic [7:0] ers, ecd;
        logic       efd, erdy;
        logic [7:0] rs, cd;
        logic [6:0] lc;
        logic       fd, rdy;
        d = inst ? 1 : 4;
        f = inst ? 1 : 2;
        n = f * 8 * (d + 1);
        if (inst) begin grid_b = g; valid_b = 1'b1; end
        else      begin grid_a = g; valid_a = 1'b1; end
        waited = 0;
        while ((inst ? ready_b : ready_a) !== 1'b1 && waited < 500) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++;
        if (waited >= 500) begin
            errors++;
            $display("FAIL %s ready_timeout grid_ready stayed low, required high within 500 cycles", name);
            return;
        end
        @(posedge clk); #1;
        if (!noise) begin
            if (inst) valid_b = 1'b0; else valid_a = 1'b0;
        end
        for (int k = 1; k <= n + 1; k++) begin
            model(g, k, d, f, ers, ecd, efd, erdy);
            rs  = inst ? row_sel_b : row_sel_a;
            cd  = inst ? col_b : col_a;
            lc  = inst ? live_b : live_a;
            fd  = inst ? done_b : done_a;
            rdy = inst ? ready_b : ready_a;
            checks += 5;
            if (rs !== ers) begin errors++; $display("FAIL %s row_sel cycle %0d got %h required %h", name, k, rs, ers); end
            if (cd !== ecd) begin errors++; $display("FAIL %s col_data cycle %0d got %h required %h", name, k, cd, ecd); end
            if (lc !== 7'($countones(g))) begin errors++; $display("FAIL %s live_count cycle %0d got %0d required %0d", name, k, lc, $countones(g)); end
            if (fd !== efd) begin errors++; $display("FAIL %s frame_done cycle %0d got %b required %b", name, k, fd, efd); end
            if (rdy !== erdy) begin errors++; $display("FAIL %s grid_ready cycle %0d got %b required %b", name, k, rdy, erdy); end
            if (noise) begin
                if (inst) grid_b = (k == n) ? next_g : rand64();
                else      grid_a = (k == n) ? next_g : rand64();
            end
            if (k <= n) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; valid_a = 1'b0; valid_b = 1'b0; grid_a = '0; grid_b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks += 2;
        if (row_sel_a !== 8'h00 || col_a !== 8'h00 || live_a !== 7'd0 || done_a !== 1'b0) begin
            errors++; $display("FAIL reset_outputs_a got rs=%h cd=%h lc=%0d fd=%b required all zero", row_sel_a, col_a, live_a, done_a);
        end
        if (row_sel_b !== 8'h00 || col_b !== 8'h00 || live_b !== 7'd0 || done_b !== 1'b0) begin
            errors++; $display("FAIL reset_outputs_b got rs=%h cd=%h lc=%0d fd=%b required all zero", row_sel_b, col_b, live_b, done_b);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ready_a !== 1'b1 || ready_b !== 1'b1) begin
            errors++; $display("FAIL reset_ready got a=%b b=%b required 1", ready_a, ready_b);
        end
    endtask

    task automatic test_basic();
        run_scan(1'b0, 64'h0000_0000_0000_0081, 1'b0, '0, "basic_81");
    endtask

    task automatic test_all_ones();
        run_scan(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, '0, "all_ones");
        run_scan(1'b0, 64'h0, 1'b0, '0, "all_zero");
    endtask

    task automatic test_hold_valid();
        run_scan(1'b0, rand64(), 1'b1, 64'h8000_0000_0000_0000, "hold_valid");
        run_scan(1'b0, 64'h8000_0000_0000_0000, 1'b0, '0, "back_to_back_80");
    endtask

    task automatic test_mid_reset();
        logic [63:0] g;
        g = rand64() | 64'h0000_00FF_0000_0000;
        grid_a = g; valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0;
        repeat (22) @(posedge clk);
        #1;
        checks += 2;
        if (row_sel_a !== 8'h10) begin errors++; $display("FAIL mid_reset_row4 row_sel got %h required 10", row_sel_a); end
        if (col_a !== g[39:32]) begin errors++; $display("FAIL mid_reset_row4 col_data got %h required %h", col_a, g[39:32]); end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (row_sel_a !== 8'h00 || col_a !== 8'h00 || live_a !== 7'd0 || done_a !== 1'b0) begin
            errors++; $display("FAIL mid_reset_clear got rs=%h cd=%h lc=%0d fd=%b required all zero", row_sel_a, col_a, live_a, done_a);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ready_a !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got %b required 1", ready_a); end
    endtask

    task automatic test_dwell1();
        run_scan(1'b1, 64'h0102_0408_1020_4080, 1'b0, '0, "dwell1_diag");
        run_scan(1'b1, rand64(), 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, "dwell1_hold");
        run_scan(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, '0, "dwell1_ones");
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            run_scan(1'b0, rand64(), 1'b0, '0, "random_a");
            run_scan(1'b1, rand64() & rand64(), 1'b0, '0, "random_b");
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        prev_done_a = 1'b0;
        prev_done_b = 1'b0;
        test_reset();
        test_basic();
        test_all_ones();
        test_hold_valid();
        test_mid_reset();
        test_dwell1();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/grid_display_scan.md
Name: grid_display_scan

Overview:
- Consumer end of the 64-bit generation output. Accepts one 8x8 grid snapshot per generation over a valid/ready handshake.
- Scans the snapshot row-by-row onto a multiplexed 8x8 LED matrix, with per-row dwell and an inter-row blanking cycle.
- Reports the live-cell count of the snapshot and signals when the snapshot has been shown for the configured number of frames.
- Sits between the game-of-life core's grid_evolve output and the board's matrix pins.

Parameters:
- DWELL_CYCLES, 4, cycles each row is driven; legal range is 1 or more.
- FRAMES_PER_GEN, 2, full 8-row scans of one snapshot before a new grid is accepted; legal range is 1 or more.

Ports:
- clk  input  1  system clock; the block uses this single clock only.
- reset  input  1  synchronous, active-high reset.
- grid  input  64  generation bitmap; cell (r,c) = grid[8*r+c].
- grid_valid  input  1  producer has a grid available; the producer must hold grid stable until accepted.
- grid_ready  output  1  block can accept a grid.
- row_sel  output  8  one-hot active-high row drive; all zeros when blank or idle.
- col_data  output  8  column data for the selected row; col_data[c] = cell (r,c).
- live_count  output  7  population of the last accepted snapshot, range 0..64.
- frame_done  output  1  one-cycle pulse when the last frame of the snapshot completes.

Behaviour:
- Reset:
  - Applies on any clk edge with reset=1, including mid-scan.
  - state=IDLE; row index, dwell counter and frame counter cleared.
  - row_sel=0, col_data=0, live_count=0, frame_done=0; the snapshot register is cleared.
  - grid_ready=1 in the first cycle after reset deasserts.
- Outputs: all are registered except grid_ready, which is the decode (state==IDLE).
- States:
  - IDLE: grid_ready=1, row_sel=0, col_data=0. On grid_valid&&grid_ready, capture grid into the snapshot, register live_count=popcount(grid), and go to SCAN with row=0, dwell=0, frame=0.
  - SCAN: row_sel=1<<row, col_data=snapshot[8*row+7 -: 8]. The dwell counter increments each cycle. After DWELL_CYCLES cycles, go to BLANK.
  - BLANK: one cycle with row_sel=0 and col_data=0 (anti-ghosting).
    - If row<7: row++ and return to SCAN.
    - If row==7 and frame<FRAMES_PER_GEN-1: frame++, row=0, return to SCAN.
    - If row==7 and frame==FRAMES_PER_GEN-1: assert frame_done for this cycle and go to IDLE.
- Latency:
  - Accept edge at cycle 0; row 0 is driven in cycles 1..DWELL_CYCLES.
  - Each row occupies DWELL_CYCLES+1 cycles, so one frame is 8*(DWELL_CYCLES+1) cycles.
  - frame_done is asserted in cycle FRAMES_PER_GEN*8*(DWELL_CYCLES+1).
  - grid_ready returns high in the following cycle.
- Handshake rules:
  - grid_valid while grid_ready=0 is ignored; there is no queuing, so the producer stalls.
  - A grid that changes while the block is not ready has no effect on the display.
- live_count is updated only on accept and holds through the scan and subsequent IDLE.
- Boundary cases:
  - All-zero grid: the full scan still runs with col_data=0 and live_count=0.
  - All-ones grid: live_count=64, which requires 7 bits and must not wrap.
  - DWELL_CYCLES=1: each row is driven for exactly 1 cycle, then blank.
  - Back-to-back grids: the earliest next acceptance is the cycle after frame_done.
- Invariant: row_sel is never multi-hot.

Decomposition:
- Package gol_pkg holds:
  - GRID_W=64, ROWS=8, COLS=8, CNT_W=7.
  - Enum scan_state_t {IDLE, SCAN, BLANK}.
- Sub-module popcount64: combinational 64-bit population count with a 7-bit output, reusable by other game-of-life statistics logic.

Test Plan:
- Reset, then grid=64'h0000_0000_0000_0081 with valid -> accepted in the cycle after reset. live_count=2. Cycles 1..4 show row_sel=8'h01 and col_data=8'h81. Cycle 5 is blank. Rows 1..7 show col_data=0.
- grid=64'hFFFF_FFFF_FFFF_FFFF -> live_count=64. frame_done is asserted exactly at cycle 80 (defaults). grid_ready=1 at cycle 81.
- Hold grid_valid=1 with changing grid during the scan -> display and live_count are unchanged. A second grid=64'h8000_0000_0000_0000 is accepted at cycle 81. Row 7 then shows col_data=8'h80 and live_count=1.
- Assert reset at cycle 23, mid row 4 -> the next cycle shows row_sel=0, col_data=0, live_count=0, frame_done=0. grid_ready=1 after reset deasserts.
- Instance with DWELL_CYCLES=1 and FRAMES_PER_GEN=1, grid=64'h0102_0408_1020_4080 -> row r shows col_data=1<<(7-r) for 1 cycle, then a blank cycle. frame_done is asserted at cycle 16.
- Throughout all tests -> assert row_sel is one-hot or zero. Assert frame_done is never high for two consecutive cycles.
